regfile_cmd_responder: RTL
==========================

REGFILE_CMD_RESPONDER -- requirements
Module: regfile_cmd_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, which is the entry width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 2, giving 2^ADDR_W entries.
REQ-003 The block SHALL have parameter RSP_DEPTH, default 2, which is the response FIFO depth (at least 1).
REQ-004 The block SHALL have port real_clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 The block SHALL have port real_rst, input, 1 bit: the reset, asynchronous, active-high.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-008 The block SHALL have port cmd_op, input, 2 bits: 00 READ, 01 WRITE, 10 SWAP, 11 ADD.
REQ-009 The block SHALL have port cmd_addr, input, ADDR_W bits: the target entry.
REQ-010 The block SHALL have port cmd_wdata, input, DATA_W bits: the write/swap/add operand.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: the response FIFO head is valid.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the head.
REQ-013 The block SHALL have port rsp_data, output, DATA_W bits: the returned entry value.
REQ-014 The block SHALL have port rsp_addr, output, ADDR_W bits: the entry address of the response.
REQ-015 The block SHALL have port clr_req, input, 1 bit: a one-cycle request to zero all entries.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in state CLEAR.

Function
REQ-017 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-018 cmd_ready SHALL be combinational: state==RUN AND clr_req==0 AND FIFO count<RSP_DEPTH. It SHALL be independent of cmd_valid and of a same-cycle pop.
REQ-019 READ SHALL push {addr, entry[addr]} into the FIFO and leave the storage unchanged.
REQ-020 WRITE SHALL set entry[addr]=cmd_wdata at the accept edge and push nothing.
REQ-021 SWAP SHALL push the old entry[addr] and set entry[addr]=cmd_wdata at the same edge.
REQ-022 ADD SHALL push the old entry[addr] and set entry[addr]=(old+cmd_wdata) mod 2^DATA_W, discarding the carry.
REQ-023 A response SHALL be visible on rsp_valid/rsp_data/rsp_addr on the cycle after the accept edge (latency 1), in acceptance order.
REQ-024 The FIFO head SHALL pop on an edge with rsp_valid AND rsp_ready; rsp outputs SHALL hold stable while rsp_valid is 1 and rsp_ready is 0.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged. Pointers SHALL wrap modulo RSP_DEPTH.
REQ-026 The state machine SHALL have two states, RUN and CLEAR.
REQ-027 In RUN, clr_req=1 SHALL move the block to CLEAR with the index counter at 0, and no command SHALL be accepted that cycle.
REQ-028 In CLEAR, each cycle SHALL write 0 to entry[idx] and increment idx. After writing index 2^ADDR_W-1 the block SHALL return to RUN, so CLEAR lasts exactly 2^ADDR_W cycles.
REQ-029 clr_req asserted during CLEAR SHALL be ignored.
REQ-030 The FIFO SHALL keep draining during CLEAR. Responses already queued SHALL keep their pre-clear values.
REQ-031 rsp_data SHALL always reflect the pre-update value for SWAP/ADD. A READ accepted on the cycle after a WRITE to the same address SHALL return the new value.

Reset
REQ-032 real_rst=1 SHALL immediately force all entries to 0, FIFO count/pointers to 0, state RUN, and idx 0.
REQ-033 During and after reset the outputs SHALL be: rsp_valid=0, rsp_data=0, rsp_addr=0, busy=0; cmd_ready SHALL follow REQ-018.
REQ-034 Reset asserted mid-CLEAR or with a non-empty FIFO SHALL discard all pending work, with no residual responses.

Structure
REQ-035 The op encodings and the RUN/CLEAR state encoding SHALL live in the shared regfile package.
REQ-036 The response FIFO SHALL be a sub-module named rsp_fifo, parameterised by width (ADDR_W+DATA_W) and depth. Storage, ops and the state machine SHALL stay in the top module.

Verification
REQ-037 Verification SHALL cover: reset, then WRITE addr2=0xA, then READ addr2 -> one response addr=2 data=0xA on the cycle after the READ accept; the WRITE gives no response.
REQ-038 Verification SHALL cover: entry1=0xE, then ADD addr1 wdata=0x3 -> response 0xE, then READ addr1 -> 0x1 (wrap-around).
REQ-039 Verification SHALL cover: rsp_ready=0 with 2 READs queued -> cmd_ready=0. Then rsp_ready=1 for one cycle -> cmd_ready=1 on the following cycle, with order preserved.
REQ-040 Verification SHALL cover: entries 0..3 = 1,2,3,4, then a clr_req pulse with cmd_valid=1 -> busy=1 for exactly 4 cycles, no accepts during that time, then READs of all four entries -> 0.
REQ-041 Verification SHALL cover: SWAP addr3 0x5 over old 0x9 -> response 0x9, then READ addr3 -> 0x5.
REQ-042 Verification SHALL cover: real_rst asserted mid-CLEAR with one queued response -> rsp_valid=0 and busy=0 immediately, and all entries read 0 afterwards.

Source files
------------

// File: rtl/regfile_cmd_responder_pkg.sv
// regfile_cmd_responder_pkg: command opcodes and controller states shared by the register-file responder.
package regfile_cmd_responder_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_ADD   = 2'b11
    } op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_cmd_responder_rsp_fifo.sv
// rsp_fifo: response queue; head is zero whenever the queue is empty.
module rsp_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 2
) (
    input  logic         real_clk,
    input  logic         real_rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         full
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop;

    always_comb begin
        valid  = count != '0;
        full   = count == CW'(DEPTH);
        do_pop = pop && valid;
        data   = valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge real_clk)
        if (push) mem[wr_ptr] <= push_data;

    always_ff @(posedge real_clk or posedge real_rst)
        if (real_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
endmodule

// File: rtl/regfile_cmd_responder.sv
// regfile_cmd_responder: small register file serving READ/WRITE/SWAP/ADD commands with queued
// responses, plus a multi-cycle clear sweep.
module regfile_cmd_responder
    import regfile_cmd_responder_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 2,
    parameter int RSP_DEPTH = 2
) (
    input  logic              real_clk,
    input  logic              real_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    input  logic              clr_req,
    output logic              busy
);
    localparam int NE = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NE];
    state_e            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    op_e               op;
    logic              fifo_full, accept, push;
    logic [DATA_W-1:0] old_val, wr_val;

    always_comb begin
        op        = op_e'(cmd_op);
        busy      = state == ST_CLEAR;
        cmd_ready = state == ST_RUN && !clr_req && !fifo_full;
        accept    = cmd_valid && cmd_ready;
        push      = accept && op != OP_WRITE;
        old_val   = mem[cmd_addr];
        wr_val    = op == OP_ADD ? old_val + cmd_wdata : cmd_wdata;
        state_nxt = state == ST_RUN ? (clr_req ? ST_CLEAR : ST_RUN)
                                    : (idx == '1 ? ST_RUN : ST_CLEAR);
    end

    always_ff @(posedge real_clk or posedge real_rst)
        if (real_rst) state <= ST_RUN;
        else          state <= state_nxt;

    // idx parks at 0 in RUN so every sweep starts at entry 0
    always_ff @(posedge real_clk or posedge real_rst)
        if (real_rst) begin
            idx <= '0;
            for (int i = 0; i < NE; i++) mem[i] <= '0;
        end else begin
            idx <= state == ST_CLEAR ? idx + 1'b1 : '0;
            if (state == ST_CLEAR) mem[idx] <= '0;
            else if (accept && op != OP_READ) mem[cmd_addr] <= wr_val;
        end

    rsp_fifo #(.W(ADDR_W + DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .real_clk (real_clk),
        .real_rst (real_rst),
        .push     (push),
        .push_data({cmd_addr, old_val}),
        .pop      (rsp_ready),
        .valid    (rsp_valid),
        .data     ({rsp_addr, rsp_data}),
        .full     (fifo_full)
    );
endmodule
